// File: rtl/gpio_host_master_pkg.sv
// Shared definitions for the host-side NPU GPIO link master: bus widths,
// command opcodes, FSM state encoding and the state-to-opcode mapping.
package gpio_host_master_pkg;

   localparam int CMD_W  = 4;
   localparam int DATA_W = 48;
   localparam int RES_W  = 16;

   // Command nibble driven onto the NPU gpio_io_i pins; bit1 of START carries the mode.
   localparam logic [CMD_W-1:0] OP_NOP      = 4'b0000;
   localparam logic [CMD_W-1:0] OP_START_M0 = 4'b0001;
   localparam logic [CMD_W-1:0] OP_START_M1 = 4'b0011;
   localparam logic [CMD_W-1:0] OP_READ     = 4'b0100;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_WAIT  = 3'd2,
      ST_READ  = 3'd3,
      ST_LAT   = 3'd4,
      ST_DRAIN = 3'd5
   } gpio_state_e;

   // Opcode the pins must carry while the FSM sits in a given state.
   function automatic logic [CMD_W-1:0] state_opcode(input gpio_state_e st, input logic mode);
      logic [CMD_W-1:0] op;
      op = OP_NOP;
      case (st)
         ST_START: op = mode ? OP_START_M1 : OP_START_M0;
         ST_READ:  op = OP_READ;
         default:  op = OP_NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/gpio_word_unpacker.sv
// Loads one 48-bit NPU word and serializes it as three 16-bit halfwords
// (r0, r1, r2) on a valid/ready stream. The last flag rides on r2 of a word
// that was loaded with load_last set. word_done pulses when r2 is accepted.
// Handshake: a halfword transfers on a cycle where res_valid and res_ready are
// both high; while res_ready is low the presented halfword and flags hold.
module gpio_word_unpacker
   import gpio_host_master_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              res_valid,
   output logic [RES_W-1:0]  res_data,
   output logic              res_last,
   input  logic              res_ready,
   output logic              word_done
);

   logic [DATA_W-1:0] word_q, word_d;
   logic [1:0]        phase_q, phase_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              fire;

   assign fire = valid_q & res_ready;

   // Next-state: load a fresh word, or advance one halfword per accepted transfer.
   always_comb begin
      word_d  = word_q;
      phase_d = phase_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (load) begin
         word_d  = load_data;
         phase_d = 2'd0;
         valid_d = 1'b1;
         last_d  = load_last;
      end else if (fire) begin
         if (phase_q == 2'd2) begin
            phase_d = 2'd0;
            valid_d = 1'b0;
         end else begin
            phase_d = phase_q + 2'd1;
         end
      end
   end

   // Serializer state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q  <= '0;
         phase_q <= 2'd0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         word_q  <= word_d;
         phase_q <= phase_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   // Halfword select for the current phase.
   always_comb begin
      res_data = word_q[15:0];
      case (phase_q)
         2'd1:    res_data = word_q[31:16];
         2'd2:    res_data = word_q[47:32];
         default: res_data = word_q[15:0];
      endcase
   end

   assign res_valid = valid_q;
   assign res_last  = valid_q & last_q & (phase_q == 2'd2);
   assign word_done = fire & (phase_q == 2'd2);

endmodule

// File: rtl/gpio_host_master.sv
// Host-side master of the NPU GPIO link. One request issues START (mode 0/1)
// for CMD_HOLD cycles, waits CAL_WAIT NOP cycles, then NUM_READS times issues
// READ for CMD_HOLD cycles, waits the read latency, captures gpio_data_i and
// streams it out as three halfwords.
// Optional build macro GPIO_HOST_SYNC_EN: gpio_data_i goes through a 2-flop
// synchronizer and the latency phase is stretched by 2 cycles to match.
// Request handshake: a request is taken on a cycle with req_valid and req_ready
// both high; req_valid while busy is dropped, not queued.
module gpio_host_master
   import gpio_host_master_pkg::*;
#(
   parameter int CMD_HOLD  = 4,
   parameter int CAL_WAIT  = 512,
   parameter int RD_LAT    = 2,
   parameter int NUM_READS = 4
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_mode,
   output logic              req_ready,
   output logic [CMD_W-1:0]  gpio_cmd_o,
   input  logic [DATA_W-1:0] gpio_data_i,
   output logic              res_valid,
   output logic [RES_W-1:0]  res_data,
   output logic              res_last,
   input  logic              res_ready,
   output logic              busy,
   output logic [2:0]        dbg_state
);

`ifdef GPIO_HOST_SYNC_EN
   localparam int LAT_LEN = RD_LAT + 2;
`else
   localparam int LAT_LEN = RD_LAT;
`endif

   localparam int HW_MAX  = (CMD_HOLD > LAT_LEN) ? CMD_HOLD : LAT_LEN;
   localparam int CNT_MAX = (HW_MAX > CAL_WAIT) ? HW_MAX : CAL_WAIT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int WCNT_W  = $clog2(NUM_READS + 1);

   localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(CMD_HOLD - 1);
   localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(CAL_WAIT - 1);
   localparam logic [CNT_W-1:0]  LAT_LAST  = CNT_W'(LAT_LEN - 1);
   localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(NUM_READS - 1);

   gpio_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
   logic              mode_q, mode_d;
   logic [CMD_W-1:0]  cmd_q, cmd_d;
   logic              load;
   logic              load_last;
   logic              word_done;
   logic [DATA_W-1:0] sample_data;

`ifdef GPIO_HOST_SYNC_EN
   logic [DATA_W-1:0] sync1_q, sync1_d;
   logic [DATA_W-1:0] sync2_q, sync2_d;

   // Synchronizer stage inputs.
   always_comb begin
      sync1_d = gpio_data_i;
      sync2_d = sync1_q;
   end

   // Two-flop synchronizer on the NPU data bus.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign sample_data = sync2_q;
`else
   assign sample_data = gpio_data_i;
`endif

   // Sequencer: next state, phase counters, capture strobe and the next command nibble.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      word_cnt_d = word_cnt_q;
      mode_d     = mode_q;
      load       = 1'b0;
      load_last  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               mode_d     = req_mode;
               word_cnt_d = '0;
               cnt_d      = '0;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               state_d = ST_WAIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               cnt_d   = '0;
               state_d = ST_READ;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_READ: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               state_d = ST_LAT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_LAT: begin
            if (cnt_q == LAT_LAST) begin
               // Capture happens on the edge that closes the last latency cycle.
               cnt_d     = '0;
               load      = 1'b1;
               load_last = (word_cnt_q == WORD_LAST);
               state_d   = ST_DRAIN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (word_done) begin
               word_cnt_d = word_cnt_q + WCNT_W'(1);
               state_d    = (word_cnt_q == WORD_LAST) ? ST_IDLE : ST_READ;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      // The pin register follows the state being entered, so the opcode is
      // aligned with the state and can only change on phase boundaries.
      cmd_d = state_opcode(state_d, mode_d);
   end

   // Sequencer and command pin registers.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         word_cnt_q <= '0;
         mode_q     <= 1'b0;
         cmd_q      <= OP_NOP;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         word_cnt_q <= word_cnt_d;
         mode_q     <= mode_d;
         cmd_q      <= cmd_d;
      end
   end

   gpio_word_unpacker u_unpacker (
      .clk       (sys_clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (sample_data),
      .load_last (load_last),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_last  (res_last),
      .res_ready (res_ready),
      .word_done (word_done)
   );

   assign gpio_cmd_o = cmd_q;
   assign req_ready  = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign dbg_state  = state_q;

endmodule
